// File: rtl/vx_fetch_tagq.sv
// Fetch stage: forwards scheduled warps to the I-cache, parks their metadata per warp,
// and rejoins I-cache responses with that metadata through a 2-entry registered queue.
module vx_fetch_tagq #(
    parameter int NUM_WARPS   = 4,
    parameter int NUM_THREADS = 4,
    parameter int PC_BITS     = 30,
    parameter int UUID_WIDTH  = 1,
    parameter int INSTR_W     = 32,
    localparam int NW_WIDTH   = (NUM_WARPS > 1) ? $clog2(NUM_WARPS) : 1
) (
    input  logic                   clk,
    input  logic                   reset,

    input  logic                   sched_valid,
    output logic                   sched_ready,
    input  logic [NW_WIDTH-1:0]    sched_wid,
    input  logic [NUM_THREADS-1:0] sched_tmask,
    input  logic [PC_BITS-1:0]     sched_pc,
    input  logic [UUID_WIDTH-1:0]  sched_uuid,

    output logic                   icache_req_valid,
    input  logic                   icache_req_ready,
    output logic [PC_BITS-1:0]     icache_req_addr,
    output logic [NW_WIDTH-1:0]    icache_req_tag,

    input  logic                   icache_rsp_valid,
    output logic                   icache_rsp_ready,
    input  logic [NW_WIDTH-1:0]    icache_rsp_tag,
    input  logic [INSTR_W-1:0]     icache_rsp_data,

    output logic                   fetch_valid,
    input  logic                   fetch_ready,
    output logic [NW_WIDTH-1:0]    fetch_wid,
    output logic [NUM_THREADS-1:0] fetch_tmask,
    output logic [PC_BITS-1:0]     fetch_pc,
    output logic [UUID_WIDTH-1:0]  fetch_uuid,
    output logic [INSTR_W-1:0]     fetch_instr,

    output logic [NUM_WARPS-1:0]   pending_mask,
    output logic                   err_spurious,
    output logic                   busy
);

    typedef struct packed {
        logic [NW_WIDTH-1:0]    wid;
        logic [NUM_THREADS-1:0] tmask;
        logic [PC_BITS-1:0]     pc;
        logic [UUID_WIDTH-1:0]  uuid;
        logic [INSTR_W-1:0]     instr;
    } entry_t;

    logic [NUM_THREADS-1:0] tbl_tmask [NUM_WARPS];
    logic [PC_BITS-1:0]     tbl_pc    [NUM_WARPS];
    logic [UUID_WIDTH-1:0]  tbl_uuid  [NUM_WARPS];

    entry_t               q0, q1, push_entry;
    logic [1:0]           count;
    logic [NUM_WARPS-1:0] pending_next;
    logic                 sched_blocked, req_fire, rsp_fire, rsp_hit, push, pop;

    // A pending warp holds the scheduler; this is normal back-pressure, not an error.
    assign sched_blocked    = pending_mask[sched_wid];
    assign icache_req_valid = reset & sched_valid & ~sched_blocked;
    assign sched_ready      = reset & icache_req_ready & ~sched_blocked;
    assign icache_req_addr  = sched_pc;
    assign icache_req_tag   = sched_wid;
    assign req_fire         = icache_req_valid & icache_req_ready;

    // Ready comes from the registered count only, so a full queue never accepts even on a pop.
    assign icache_rsp_ready = reset & (count < 2'd2);
    assign rsp_fire         = icache_rsp_valid & icache_rsp_ready;
    assign rsp_hit          = pending_mask[icache_rsp_tag];
    assign push             = rsp_fire & rsp_hit;

    assign fetch_valid = (count != 2'd0);
    assign pop         = fetch_valid & fetch_ready;
    assign fetch_wid   = q0.wid;
    assign fetch_tmask = q0.tmask;
    assign fetch_pc    = q0.pc;
    assign fetch_uuid  = q0.uuid;
    assign fetch_instr = q0.instr;
    assign busy        = (|pending_mask) | fetch_valid;

    always_comb begin
        push_entry.wid   = icache_rsp_tag;
        push_entry.tmask = tbl_tmask[icache_rsp_tag];
        push_entry.pc    = tbl_pc[icache_rsp_tag];
        push_entry.uuid  = tbl_uuid[icache_rsp_tag];
        push_entry.instr = icache_rsp_data;
    end

    always_comb begin
        pending_next = pending_mask;
        if (push)
            pending_next[icache_rsp_tag] = 1'b0;
        if (req_fire)
            pending_next[sched_wid] = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            pending_mask <= '0;
            count        <= 2'd0;
            err_spurious <= 1'b0;
        end else begin
            pending_mask <= pending_next;
            if (rsp_fire && !rsp_hit)
                err_spurious <= 1'b1;
            case ({push, pop})
                2'b10:   count <= count + 2'd1;
                2'b01:   count <= count - 2'd1;
                default: count <= count;
            endcase
        end
    end

    // Data storage needs no reset; validity is carried by count and pending_mask.
    always_ff @(posedge clk) begin
        if (req_fire) begin
            tbl_tmask[sched_wid] <= sched_tmask;
            tbl_pc[sched_wid]    <= sched_pc;
            tbl_uuid[sched_wid]  <= sched_uuid;
        end
        case ({push, pop})
            2'b10: begin
                if (count == 2'd0)
                    q0 <= push_entry;
                else
                    q1 <= push_entry;
            end
            2'b01:   q0 <= q1;
            2'b11:   q0 <= push_entry;
            default: ;
        endcase
    end

endmodule
